// File: rtl/fpu_xfer_pkg.sv
// fpu_xfer_pkg: shared encodings for the FPU load/store-multiple sequencer.
// Holds the FSM state type, the single/double precision select values
// and the memory word size in bytes.
package fpu_xfer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic SOD_SINGLE = 1'b0;
  localparam logic SOD_DOUBLE = 1'b1;

  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/fpu_xfer_ptr.sv
// fpu_xfer_ptr: register pointer and beat tracker for a multi-register
// transfer.
//
// The command is captured on load. After that, each advance moves one
// memory beat forward. A single takes one beat per register. A double
// takes two beats per register, low word first.
//
// The pointer wraps modulo 32 for singles and modulo 16 for doubles.
// last flags the final beat of the whole transfer.
module fpu_xfer_ptr
  import fpu_xfer_pkg::*;
#(
  parameter int MAX_CNT_W = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic                 sod,
  input  logic [4:0]           first_reg,
  input  logic [MAX_CNT_W-1:0] count,
  input  logic                 advance,
  output logic                 dbl,
  output logic                 half,
  output logic                 last,
  output logic [3:0]           reg_addr,
  output logic                 reg_sel
);

  logic                 sod_q;
  logic [4:0]           idx_q;
  logic                 half_q;
  logic [MAX_CNT_W-1:0] left_q;

  assign dbl      = (sod_q == SOD_DOUBLE);
  assign half     = half_q;
  assign last     = (left_q == MAX_CNT_W'(1)) && (!dbl || half_q);
  assign reg_addr = dbl ? idx_q[3:0] : idx_q[4:1];
  assign reg_sel  = dbl ? 1'b0 : idx_q[0];

  // Capture the command, then step half-beat / register index per beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sod_q  <= SOD_SINGLE;
      idx_q  <= '0;
      half_q <= 1'b0;
      left_q <= '0;
    end else if (load) begin
      sod_q  <= sod;
      idx_q  <= (sod == SOD_DOUBLE) ? {1'b0, first_reg[3:0]} : first_reg;
      half_q <= 1'b0;
      left_q <= count;
    end else if (advance) begin
      if (dbl && !half_q) begin
        half_q <= 1'b1;
      end else begin
        half_q <= 1'b0;
        left_q <= left_q - MAX_CNT_W'(1);
        idx_q  <= dbl ? {1'b0, idx_q[3:0] + 4'd1} : idx_q + 5'd1;
      end
    end
  end

endmodule

// File: rtl/fpu_xfer_seq.sv
// fpu_xfer_seq: multi-cycle VLDM/VSTM sequencer between the FPU register
// file and a 32-bit memory port. busy stalls the pipeline while a
// transfer runs.
//
// Optional feature:
//   FPU_XFER_WRITEBACK_EN adds wb_valid and wb_addr. These report the
//   base-register writeback address alongside done.
//
// Memory handshake:
//   mem_req is the valid. mem_ready is the ready. A beat completes on a
//   cycle where both are high. While mem_ready is low, every memory and
//   regfile output holds its value.
module fpu_xfer_seq
  import fpu_xfer_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MAX_CNT_W = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 is_load,
  input  logic                 sod,
  input  logic [4:0]           first_reg,
  input  logic [MAX_CNT_W-1:0] count,
  input  logic [ADDR_W-1:0]    base_addr,
  output logic                 busy,
  output logic                 done,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic                 mem_ready,
  input  logic [31:0]          mem_rdata,
  output logic                 rf_we,
  output logic [3:0]           rf_wa,
  output logic                 rf_a3,
  output logic [63:0]          rf_wd,
  output logic [3:0]           rf_ra,
  output logic                 rf_a1,
  output logic                 rf_sod,
  input  logic [63:0]          rf_rd,
`ifdef FPU_XFER_WRITEBACK_EN
  output logic                 wb_valid,
  output logic [ADDR_W-1:0]    wb_addr,
`endif
  output state_t               dbg_state
);

  state_t state, next_state;

  logic              accept;
  logic              beat_done;
  logic              load_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       lo_q;
  logic              rf_we_q;
  logic [3:0]        rf_wa_q;
  logic              rf_a3_q;
  logic [63:0]       rf_wd_q;

  logic              dbl;
  logic              half;
  logic              last;
  logic [3:0]        reg_addr;
  logic              reg_sel;

  fpu_xfer_ptr #(.MAX_CNT_W(MAX_CNT_W)) u_ptr (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (accept),
    .sod       (sod),
    .first_reg (first_reg),
    .count     (count),
    .advance   (beat_done),
    .dbl       (dbl),
    .half      (half),
    .last      (last),
    .reg_addr  (reg_addr),
    .reg_sel   (reg_sel)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  // Next state, handshake strobes and status flags.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    beat_done  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    mem_req    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          next_state = (count == '0) ? ST_FLUSH : ST_XFER;
        end
      end
      ST_XFER: begin
        busy      = 1'b1;
        mem_req   = 1'b1;
        beat_done = mem_ready;
        if (mem_ready && last) next_state = ST_FLUSH;
      end
      ST_FLUSH: begin
        busy       = 1'b1;
        done       = 1'b1;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Beat address, held low word of a double, and the registered regfile write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      load_q  <= 1'b0;
      addr_q  <= '0;
      lo_q    <= '0;
      rf_we_q <= 1'b0;
      rf_wa_q <= '0;
      rf_a3_q <= 1'b0;
      rf_wd_q <= '0;
    end else begin
      rf_we_q <= 1'b0;
      rf_wa_q <= '0;
      rf_a3_q <= 1'b0;
      rf_wd_q <= '0;
      if (accept) begin
        load_q <= is_load;
        addr_q <= base_addr;
      end else if (beat_done) begin
        addr_q <= addr_q + ADDR_W'(WORD_BYTES);
        if (load_q) begin
          if (dbl && !half) begin
            lo_q <= mem_rdata;
          end else begin
            rf_we_q <= 1'b1;
            rf_wa_q <= reg_addr;
            rf_a3_q <= reg_sel;
            rf_wd_q <= dbl ? {mem_rdata, lo_q} : {32'h0, mem_rdata};
          end
        end
      end
    end
  end

  assign mem_we    = mem_req && !load_q;
  assign mem_addr  = mem_req ? addr_q : '0;
  assign mem_wdata = mem_we ? (half ? rf_rd[63:32] : rf_rd[31:0]) : '0;
  assign rf_ra     = mem_we ? reg_addr : '0;
  assign rf_a1     = mem_we ? reg_sel : 1'b0;
  assign rf_sod    = busy ? dbl : SOD_SINGLE;
  assign rf_we     = rf_we_q;
  assign rf_wa     = rf_wa_q;
  assign rf_a3     = rf_a3_q;
  assign rf_wd     = rf_wd_q;
  assign dbg_state = state;

`ifdef FPU_XFER_WRITEBACK_EN
  // The beat address has already advanced past the last beat,
  // so in FLUSH it equals base + 4 * total_beats.
  assign wb_valid = done;
  assign wb_addr  = done ? addr_q : '0;
`endif

endmodule

// File: tb/tb_fpu_xfer_seq.sv
// tb_fpu_xfer_seq: directed bench for fpu_xfer_seq.
// A table of whole transfers is checked beat by beat against a queue
// model. Hand-written sequences cover stall, zero count and mid-op reset.
module tb_fpu_xfer_seq;
  import fpu_xfer_pkg::*;

  localparam int ADDR_W    = 32;
  localparam int MAX_CNT_W = 5;

  logic                 clk       = 1'b0;
  logic                 reset_n   = 1'b0;
  logic                 start     = 1'b0;
  logic                 is_load   = 1'b0;
  logic                 sod       = 1'b0;
  logic [4:0]           first_reg = '0;
  logic [MAX_CNT_W-1:0] count     = '0;
  logic [ADDR_W-1:0]    base_addr = '0;
  logic                 mem_ready = 1'b1;
  logic                 busy, done, mem_req, mem_we;
  logic [ADDR_W-1:0]    mem_addr;
  logic [31:0]          mem_wdata, mem_rdata;
  logic                 rf_we, rf_a3, rf_a1, rf_sod;
  logic [3:0]           rf_wa, rf_ra;
  logic [63:0]          rf_wd, rf_rd;
  state_t               dbg_state;
`ifdef FPU_XFER_WRITEBACK_EN
  logic                 wb_valid;
  logic [ADDR_W-1:0]    wb_addr;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Clock.
  always #5 clk = ~clk;

  fpu_xfer_seq #(.ADDR_W(ADDR_W), .MAX_CNT_W(MAX_CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .is_load(is_load), .sod(sod),
    .first_reg(first_reg), .count(count), .base_addr(base_addr),
    .busy(busy), .done(done), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .rf_we(rf_we), .rf_wa(rf_wa), .rf_a3(rf_a3),
    .rf_wd(rf_wd), .rf_ra(rf_ra), .rf_a1(rf_a1), .rf_sod(rf_sod), .rf_rd(rf_rd),
`ifdef FPU_XFER_WRITEBACK_EN
    .wb_valid(wb_valid), .wb_addr(wb_addr),
`endif
    .dbg_state(dbg_state)
  );

  // Memory content is a fixed function of the address.
  function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  // Register file content is a fixed function of the read address.
  function automatic logic [63:0] rf_model(input logic [3:0] ra, input logic a1, input logic s);
    if (s) return {16'hAAAA, 12'h000, ra, 16'hBBBB, 12'h000, ra};
    return {32'h0, 16'hCCCC, 11'h000, ra, a1};
  endfunction

  assign mem_rdata = mem_word(mem_addr);
  assign rf_rd     = rf_model(rf_ra, rf_a1, rf_sod);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        is_load;
    logic        sod;
    logic [4:0]  first;
    logic [4:0]  cnt;
    logic [31:0] base;
    int          beats;
    int          lat;
    logic [3:0]  fw;
    logic        fa;
    logic [3:0]  lw;
    logic        la;
    logic [31:0] end_addr;
  } vec_t;

  vec_t tbl[7];

  task automatic check_quiet(input string tag);
    check({tag, "_busy"},     busy, 0);
    check({tag, "_done"},     done, 0);
    check({tag, "_mem_req"},  mem_req, 0);
    check({tag, "_mem_we"},   mem_we, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_wdata"},    mem_wdata, 0);
    check({tag, "_rf_we"},    rf_we, 0);
    check({tag, "_rf_wa"},    {rf_wa, rf_a3}, 0);
    check({tag, "_rf_wd"},    rf_wd, 0);
    check({tag, "_rf_ra"},    {rf_ra, rf_a1}, 0);
    check({tag, "_rf_sod"},   rf_sod, 0);
    check({tag, "_state"},    dbg_state, ST_IDLE);
`ifdef FPU_XFER_WRITEBACK_EN
    check({tag, "_wb"},       {wb_valid, wb_addr}, 0);
`endif
  endtask

  // Run one table transfer with mem_ready high, checking every beat and write.
  task automatic run_cmd(input vec_t v);
    logic [68:0] beat_q[$];
    logic [68:0] wr_q[$];
    logic [68:0] e;
    logic [4:0]  s;
    logic [3:0]  d, wa, fw, lw;
    logic        a, fa, la, seen;
    logic [63:0] rdv;
    logic [31:0] a0, a1v, last_addr;
    int          beat, nbeat, nwr, got_lat;
    beat = 0;
    for (int r = 0; r < int'(v.cnt); r++) begin
      s   = v.first + 5'(r);
      d   = v.first[3:0] + 4'(r);
      wa  = v.sod ? d : s[4:1];
      a   = v.sod ? 1'b0 : s[0];
      rdv = rf_model(wa, a, v.sod);
      a0  = v.base + 32'(4 * beat);
      a1v = a0 + 32'd4;
      beat_q.push_back({a0, rdv[31:0], wa, a});
      if (v.sod) begin
        beat_q.push_back({a1v, rdv[63:32], wa, a});
        wr_q.push_back({wa, a, mem_word(a1v), mem_word(a0)});
        beat += 2;
      end else begin
        wr_q.push_back({wa, a, 32'h0, mem_word(a0)});
        beat += 1;
      end
    end
    @(posedge clk); #1;
    start = 1'b1; is_load = v.is_load; sod = v.sod; first_reg = v.first;
    count = v.cnt; base_addr = v.base; mem_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    got_lat = -1; nbeat = 0; nwr = 0; seen = 1'b0;
    fw = '0; fa = 1'b0; lw = '0; la = 1'b0; last_addr = '0;
    for (int c = 1; c <= v.lat + 3 && got_lat < 0; c++) begin
      @(negedge clk);
      if (c == 1) check("busy_after_accept", busy, 1);
      if (mem_req) begin
        if (beat_q.size() == 0) begin
          check("extra_mem_req", mem_req, 0);
        end else begin
          e = beat_q.pop_front();
          check("mem_addr", mem_addr, e[68:37]);
          check("mem_we", mem_we, !v.is_load);
          if (!v.is_load) begin
            check("mem_wdata", mem_wdata, e[36:5]);
            check("rf_ra", {rf_ra, rf_a1}, e[4:0]);
            if (!seen) begin fw = rf_ra; fa = rf_a1; seen = 1'b1; end
            lw = rf_ra; la = rf_a1;
          end
          last_addr = mem_addr;
          nbeat++;
        end
      end
      if (rf_we) begin
        nwr++;
        if (wr_q.size() != 0) begin
          e = wr_q.pop_front();
          check("rf_write", {rf_wa, rf_a3, rf_wd}, e);
          check("rf_sod_load", rf_sod, v.sod);
        end
        if (!seen) begin fw = rf_wa; fa = rf_a3; seen = 1'b1; end
        lw = rf_wa; la = rf_a3;
      end
      if (done) begin
        got_lat = c;
        check("busy_at_done", busy, 1);
        check("mem_req_at_done", mem_req, 0);
`ifdef FPU_XFER_WRITEBACK_EN
        check("wb_valid", wb_valid, 1);
        check("wb_addr", wb_addr, v.end_addr);
`endif
      end
    end
    check("done_latency", got_lat, v.lat);
    check("beat_count", nbeat, v.beats);
    check("rf_we_count", nwr, v.is_load ? int'(v.cnt) : 0);
    check("first_reg", {fw, fa}, {v.fw, v.fa});
    check("last_reg", {lw, la}, {v.lw, v.la});
    check("end_addr", last_addr + 32'd4, v.end_addr);
    @(negedge clk);
    check("busy_after_done", busy, 0);
  endtask

  // Double load of D3 with mem_ready low for three cycles on the high beat.
  // A start pulse arrives mid-stall and must be ignored.
  task automatic stall_seq();
    @(posedge clk); #1;
    start = 1'b1; is_load = 1'b1; sod = 1'b1; first_reg = 5'd3;
    count = 5'd1; base_addr = 32'h300; mem_ready = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    check("st_c1_addr", {mem_req, mem_addr}, {1'b1, 32'h300});
    check("st_c1_rf_we", rf_we, 0);
    @(posedge clk); #1; mem_ready = 1'b0;
    @(negedge clk);
    check("st_c2_addr", {mem_req, mem_addr}, {1'b1, 32'h304});
    check("st_c2_rf_we", rf_we, 0);
    @(posedge clk); #1;
    start = 1'b1; is_load = 1'b0; base_addr = 32'hF00; count = 5'd5;
    @(negedge clk);
    check("st_c3_addr", {mem_req, mem_we, mem_addr}, {2'b10, 32'h304});
    check("st_c3_rf_we", rf_we, 0);
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    check("st_c4_addr", {mem_req, mem_addr}, {1'b1, 32'h304});
    check("st_c4_rf_we", rf_we, 0);
    @(posedge clk); #1; mem_ready = 1'b1;
    @(negedge clk);
    check("st_c5_addr", {mem_req, mem_addr}, {1'b1, 32'h304});
    check("st_c5_done", {done, rf_we}, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("st_c6_done", {done, busy}, 2'b11);
    check("st_c6_write", {rf_we, rf_wa, rf_a3, rf_sod}, {1'b1, 4'd3, 1'b0, 1'b1});
    check("st_c6_wd", rf_wd, 64'h595E_0304_595A_0300);
    @(posedge clk); #1;
    @(negedge clk);
    check("st_c7_idle", {busy, rf_we, mem_req}, 0);
  endtask

  // count = 0: FLUSH right after accept, no beats, start while busy ignored.
  task automatic zero_seq();
    @(posedge clk); #1;
    start = 1'b1; is_load = 1'b1; sod = 1'b0; first_reg = 5'd9;
    count = 5'd0; base_addr = 32'h700; mem_ready = 1'b1;
    @(posedge clk); #1;
    count = 5'd2;
    @(negedge clk);
    check("z_c1_done", {busy, done}, 2'b11);
    check("z_c1_quiet", {mem_req, rf_we}, 0);
`ifdef FPU_XFER_WRITEBACK_EN
    check("z_c1_wb", {wb_valid, wb_addr}, {1'b1, 32'h700});
`endif
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    check("z_c2_idle", {busy, done, mem_req, rf_we}, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("z_c3_idle", {busy, done, mem_req, rf_we}, 0);
  endtask

  // Reset after the low beat of a double load: nothing written, all quiet.
  task automatic reset_seq();
    @(posedge clk); #1;
    start = 1'b1; is_load = 1'b1; sod = 1'b1; first_reg = 5'd5;
    count = 5'd2; base_addr = 32'h500; mem_ready = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    check("r_c1_addr", {mem_req, mem_addr}, {1'b1, 32'h500});
    check("r_c1_rf_we", rf_we, 0);
    @(posedge clk); #1; reset_n = 1'b0;
    @(negedge clk);
    check_quiet("r_mid");
    @(posedge clk); #1; reset_n = 1'b1;
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 5'd5,  5'd3,  32'h100,  3,  4,  4'd2,  1'b1, 4'd3,  1'b1, 32'h10C};
    tbl[1] = '{1'b0, 1'b1, 5'd14, 5'd3,  32'h200,  6,  7,  4'd14, 1'b0, 4'd0,  1'b0, 32'h218};
    tbl[2] = '{1'b0, 1'b0, 5'd30, 5'd3,  32'h80,   3,  4,  4'd15, 1'b0, 4'd0,  1'b0, 32'h8C};
    tbl[3] = '{1'b1, 1'b1, 5'h17, 5'd2,  32'h1000, 4,  5,  4'd7,  1'b0, 4'd8,  1'b0, 32'h1010};
    tbl[4] = '{1'b1, 1'b0, 5'd0,  5'd4,  32'h40,   4,  5,  4'd0,  1'b0, 4'd1,  1'b1, 32'h50};
    tbl[5] = '{1'b1, 1'b1, 5'd15, 5'd16, 32'h2000, 32, 33, 4'd15, 1'b0, 4'd14, 1'b0, 32'h2080};
    tbl[6] = '{1'b1, 1'b0, 5'd1,  5'd31, 32'h0,    31, 32, 4'd0,  1'b1, 4'd15, 1'b1, 32'h7C};

    #12;
    check_quiet("reset");
    @(posedge clk); #1; reset_n = 1'b1;

    for (int i = 0; i < 7; i++) run_cmd(tbl[i]);
    stall_seq();
    zero_seq();
    reset_seq();
    run_cmd(tbl[3]);
    run_cmd(tbl[1]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fpu_xfer_seq.md
Name: fpu_xfer_seq

Overview:
Multi-cycle sequencer for FPU load-multiple and store-multiple transfers (VLDM/VSTM style) between the FPU register file and a 32-bit memory port.
- Accepts one command: direction, precision, first register, register count, base address.
- Walks the register range one memory beat at a time. Drives the FPU regfile write port (loads) or read port 1 (stores).
- Sits between the FPU decode/control and the regfile/memory interface; stalls the pipeline via busy.

Parameters:
ADDR_W, 32, memory address width
MAX_CNT_W, 5, width of register count field (max 16 doubles / 31 singles)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
start  input  1  command valid; accepted only in IDLE
is_load  input  1  1 = memory->regfile, 0 = regfile->memory
sod  input  1  0 = single, 1 = double (same encoding as regfile sod)
first_reg  input  5  single: S index {reg[3:0],A}; double: D index in [3:0], bit 4 ignored
count  input  MAX_CNT_W  number of registers to transfer
base_addr  input  ADDR_W  word-aligned start address
busy  output  1  high from accept until done inclusive
done  output  1  one-cycle completion pulse
mem_req  output  1  beat request
mem_we  output  1  1 = write (store)
mem_addr  output  ADDR_W  beat address
mem_wdata  output  32  store data
mem_ready  input  1  beat accepted/completed this cycle
mem_rdata  input  32  load data, valid when mem_req && mem_ready
rf_we  output  1  regfile we3
rf_wa  output  4  regfile wa3
rf_a3  output  1  regfile A3
rf_wd  output  64  regfile wd3
rf_ra  output  4  regfile ra1
rf_a1  output  1  regfile A1
rf_sod  output  1  regfile sod
rf_rd  input  64  regfile rd1

Behaviour:
- Reset: state IDLE. Outputs busy, done, mem_req, mem_we, rf_we, rf_sod = 0. All address/data outputs = 0.
- States: IDLE, XFER, FLUSH.
- IDLE:
  - start=1 latches all command fields and the beat pointer; busy=1 next cycle.
  - count=0 -> go to FLUSH (no beats, no rf writes).
  - Otherwise -> XFER.
- XFER:
  - mem_req=1 from the cycle after accept.
  - Beat completes on mem_req && mem_ready; mem_ready low holds every output stable.
  - mem_addr = base_addr + 4*beat_index.
  - Beats per register: 1 (single) or 2 (double: low word first, then high word).
- Register pointer:
  - Single: 5-bit index, increments modulo 32 (S31 -> S0).
  - Double: 4-bit index, modulo 16 (D15 -> D0).
  - rf_wa/rf_ra = index[4:1] for singles, index[3:0] for doubles.
  - rf_a3/rf_a1 = index[0] for singles, 0 for doubles.
- Loads:
  - Single: rf_we pulses in the cycle after its beat completes, with rf_wd = {32'b0, registered word}.
  - Double: low word is held internally; rf_we pulses in the cycle after the high beat, with rf_wd = {high, low}.
  - rf_sod = latched sod while busy.
- Stores:
  - rf_ra/rf_a1 are driven combinationally from the current pointer; rf_sod = sod.
  - mem_wdata = rf_rd[31:0] for singles and double beat 0; rf_rd[63:32] for double beat 1.
  - rf_we is always 0.
- Last beat complete -> FLUSH. FLUSH lasts one cycle: done=1, final load rf_we (if any) in the same cycle, busy=1. Then IDLE.
- Latency: accept at cycle N, first mem_req at N+1. With mem_ready tied high, done arrives at N + beats + 1.
- start while busy: ignored, with no effect on the in-flight transfer.
- reset_n asserted mid-transfer: immediate return to IDLE. Registers already written keep their new values; no partial double is written.

Optional Feature:
FPU_XFER_WRITEBACK_EN
- Defined: adds outputs wb_valid (1) and wb_addr (ADDR_W).
  - wb_valid pulses together with done.
  - wb_addr = base_addr + 4*total_beats, for base-register writeback (! form).
  - Reset value 0.
- Undefined: ports and logic absent; no writeback.

Decomposition:
- Package fpu_xfer_pkg:
  - state encoding constants (IDLE/XFER/FLUSH)
  - SOD_SINGLE/SOD_DOUBLE
  - WORD_BYTES=4
- Sub-module fpu_xfer_ptr: register-pointer/beat counter. Inputs: sod, first_reg, count. Tracks index wrap, half-beat and last flags.
- FSM and mux logic stay in the top module.

Test Plan:
- Single load: is_load=1, sod=0, first_reg=5, count=3, base=0x100, ready=1. Expect:
  - addrs 0x100/0x104/0x108
  - writes (wa=2,a3=1), (wa=3,a3=0), (wa=3,a3=1)
  - done at N+4
- Double store: sod=1, first_reg=D14, count=3, base=0x200. rf_rd returns 0xAAAA_0001_BBBB_0002-style patterns. Expect:
  - 6 beats with low word then high word per register
  - rf_ra sequence 14, 15, 0 (wrap)
- Stall: double load count=1 with mem_ready low for 3 cycles on the high beat. Expect:
  - mem_addr/mem_req held stable
  - exactly one rf_we with rf_wd = {hi, lo}
- count=0 start: done one cycle after FLUSH entry; no mem_req, no rf_we; start pulses while busy have no effect.
- Reset mid-op: reset_n low after the low beat of a double load. Expect no rf_we, all outputs 0; a new command afterwards runs cleanly.
- FPU_XFER_WRITEBACK_EN: single load, count=4, base=0x40 -> wb_valid with done, wb_addr=0x50.
